fetch_realign: RTL and testbench
================================

Name: fetch_realign

Overview:
- Sits directly upstream of the instruction queue, between the I$ fetch response and the queue's instr/addr/valid inputs.
- Splits each aligned fetch block into individual RVC (16-bit) and RV (32-bit) instructions, each with its own PC.
- Stitches together 32-bit instructions that straddle two consecutive fetch blocks, and skips leading halfwords when a fetch starts mid-block after a redirect.
- Output is combinational (0-cycle latency). The only state is the saved lower half of a straddling instruction.

Parameters:
FETCH_WIDTH, 32, fetch block width in bits; legal values 32 or 64.
N (derived, not overridable), FETCH_WIDTH/16, halfword slots per block; also the number of output slots.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  discard saved state (redirect, replay or pipeline flush)
valid_i  in  1  fetch block valid
address_i  in  64  fetch address; low bits give the starting halfword
data_i  in  FETCH_WIDTH  fetch block data, little-endian halfwords
valid_o  out  N  per-slot instruction valid, packed from slot 0 upward
instr_o  out  N x 32  instruction; RVC zero-extended to 32 bits
addr_o  out  N x 64  PC of each instruction
unaligned_o  out  1  lower half of a straddling instruction is held
unaligned_addr_o  out  64  PC of the held instruction

Behaviour:
- Reset (rst_ni low, asynchronous):
  - unaligned_q=0, saved_hw_q=0, saved_addr_q=0.
  - Hence unaligned_o=0, unaligned_addr_o=0, valid_o=0.
- Definitions:
  - hw[k] = data_i[16k+15:16k].
  - B = log2(FETCH_WIDTH/8).
  - base = {address_i[63:B], B'0}.
  - s = address_i[B-1:1] (start slot).
  - "Compressed" means hw[1:0] != 2'b11.
- Decode (combinational, only when valid_i=1 and flush_i=0; otherwise valid_o=0):
  - If unaligned_q=1 and s==0:
    - Emit {hw[0], saved_hw_q} at saved_addr_q in output slot 0.
    - Pointer p=1.
  - If unaligned_q=1 and s!=0: the saved half is stale. Drop it; p=s.
  - Otherwise p=s.
  - Loop while p<N:
    - hw[p] compressed: emit {16'h0, hw[p]} at base+2p; p+=1.
    - hw[p] not compressed and p+1<N: emit {hw[p+1], hw[p]} at base+2p; p+=2.
    - hw[p] not compressed and p==N-1: save hw[p] with address base+2p as the new straddling half; p=N.
  - Emitted instructions fill output slots 0,1,... in program order.
  - The unused upper slots have valid_o=0; their instr_o and addr_o are don't-care.
  - At most N instructions are emitted per block.
- State update (posedge clk_i):
  - flush_i=1: unaligned_q<=0. flush_i has priority over valid_i.
  - valid_i=1: unaligned_q<=1 iff this block ends in a saved half, else 0.
    - When saving, also load saved_hw_q and saved_addr_q.
    - A consumed or stale saved half is cleared.
  - valid_i=0: all state held.
- Back-pressure: the block has no ready input.
  - Overflow is recovered by the queue's replay, which the fetch stage must accompany with flush_i.
  - The replay address then restarts decode cleanly.
- Address arithmetic: 64-bit, no wrap handling required beyond natural modulo 2^64.
- Assertions:
  - valid_o is contiguous from bit 0.
  - unaligned_addr_o[0]==0.

Test Plan:
- Plain 32-bit instruction (FW=32): addr 0x1000, data 0x00A50513 -> valid_o=01, instr_o[0]=0x00A50513, addr_o[0]=0x1000, unaligned_o=0 next cycle.
- Two RVC: addr 0x1000, data 0x45014501 -> valid_o=11, instr_o[0]=0x00004501 @0x1000, instr_o[1]=0x00004501 @0x1002.
- Straddle across blocks:
  - Cycle 1: addr 0x2000, data 0x05134501 -> valid_o=01, 0x4501 @0x2000; next cycle unaligned_o=1, unaligned_addr_o=0x2002.
  - Cycle 2: addr 0x2004, data 0x450100A5 -> valid_o=11, 0x00A50513 @0x2002, 0x00004501 @0x2006; unaligned_o=0 afterwards.
- Mid-block start: addr 0x3002, data 0x4501FFFF -> valid_o=01, 0x00004501 @0x3002; the lower halfword is ignored.
- Flush kills saved half: set up the cycle-1 state above, then flush_i=1 for one cycle (valid_o=00) -> unaligned_o=0. Then addr 0x2004, data 0x450100A5 -> 0x000000A5 @0x2004, 0x00004501 @0x2006.
- Hold and reset:
  - With a saved half, valid_i=0 for 3 cycles -> valid_o=00, unaligned_o stays 1, unaligned_addr_o unchanged.
  - Asserting rst_ni low mid-hold -> unaligned_o=0 immediately.
- FW=64 variant: addr 0x4000, data 0x0513_4501_00A5_0513 -> 0x00A50513 @0x4000, 0x00004501 @0x4004; 0x0513 saved at 0x4006.

Source files
------------

// File: rtl/fetch_realign_if.sv
// -----------------------------------------------------------------------------
// fetch_realign_if
//   Groups the fetch-response side and the instruction-queue side of the
//   fetch realigner into one bundle.
//
//   Handshake: there is no ready. The fetch stage asserts valid_i for one cycle
//   per fetch block, and that block is consumed on that clock edge. Each
//   valid_o[k] marks an instruction that the queue must take in the same
//   cycle. Overflow is recovered by a replay together with flush_i.
//
//   Signals:
//     flush_i           discard the held straddling half
//     valid_i           fetch block valid
//     address_i[63:0]   fetch address; low bits select the starting halfword
//     data_i            fetch block, little-endian halfwords
//     valid_o[N]        per-slot instruction valid, packed from slot 0
//     instr_o[N][32]    instruction; RVC zero-extended
//     addr_o[N][64]     PC of each instruction
//     unaligned_o       lower half of a straddling instruction is held
//     unaligned_addr_o  PC of the held instruction
//   Modports: master = fetch stage / queue side, slave = realigner.
// -----------------------------------------------------------------------------
interface fetch_realign_if #(
    parameter int unsigned FETCH_WIDTH = 32
) ();
    localparam int unsigned N = FETCH_WIDTH / 16;

    logic                   flush_i;
    logic                   valid_i;
    logic [63:0]            address_i;
    logic [FETCH_WIDTH-1:0] data_i;
    logic [N-1:0]           valid_o;
    logic [N-1:0][31:0]     instr_o;
    logic [N-1:0][63:0]     addr_o;
    logic                   unaligned_o;
    logic [63:0]            unaligned_addr_o;

    modport master (
        output flush_i, valid_i, address_i, data_i,
        input  valid_o, instr_o, addr_o, unaligned_o, unaligned_addr_o
    );

    modport slave (
        input  flush_i, valid_i, address_i, data_i,
        output valid_o, instr_o, addr_o, unaligned_o, unaligned_addr_o
    );
endinterface

// File: rtl/fetch_realign.sv
// -----------------------------------------------------------------------------
// fetch_realign
//   Splits an aligned fetch block into individual RVC/RV instructions, each
//   with its own PC. Decode is purely combinational. The only state is the
//   lower half of a 32-bit instruction that straddles into the next block.
//
//   Ports:
//     clk_i   clock
//     rst_ni  asynchronous active-low reset
//     bus     fetch_realign_if.slave (fetch block in, per-slot instructions out)
//   Parameter FETCH_WIDTH: 32 or 64. There are FETCH_WIDTH/16 output slots.
// -----------------------------------------------------------------------------
module fetch_realign #(
    parameter int unsigned FETCH_WIDTH = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    fetch_realign_if.slave bus
);
    localparam int unsigned N  = FETCH_WIDTH / 16;
    localparam int unsigned B  = $clog2(FETCH_WIDTH / 8);
    localparam int unsigned IW = $clog2(N);

    // State: the held straddling half and its PC.
    logic        unaligned_q, unaligned_d;
    logic [15:0] saved_hw_q, saved_hw_d;
    logic [63:0] saved_addr_q, saved_addr_d;

    logic [B-2:0]           start_slot;
    logic [63:0]            base;
    // One spare zero halfword on top, so "next halfword" is always in range.
    logic [FETCH_WIDTH+15:0] data_ext;
    logic                   unused_addr_bit;

    logic [N-1:0]       slot_valid;
    logic [N-1:0][31:0] slot_instr;
    logic [N-1:0][63:0] slot_addr;
    logic [IW:0]        cnt;
    logic               skip;
    logic [15:0]        hw;

    assign start_slot      = bus.address_i[B-1:1];
    assign base            = {bus.address_i[63:B], {B{1'b0}}};
    assign data_ext        = {16'h0000, bus.data_i};
    assign unused_addr_bit = bus.address_i[0];

    always_comb begin
        slot_valid   = '0;
        slot_instr   = '0;
        slot_addr    = '0;
        unaligned_d  = unaligned_q;
        saved_hw_d   = saved_hw_q;
        saved_addr_d = saved_addr_q;
        cnt          = '0;
        skip         = 1'b0;
        hw           = '0;
        if (bus.flush_i) begin
            unaligned_d = 1'b0;
        end else if (bus.valid_i) begin
            // Any held half is either consumed here or stale; only a new
            // straddle at the top of this block sets it again.
            unaligned_d = 1'b0;
            if (unaligned_q && (start_slot == '0)) begin
                slot_valid[0] = 1'b1;
                slot_instr[0] = {bus.data_i[15:0], saved_hw_q};
                slot_addr[0]  = saved_addr_q;
                cnt           = (IW+1)'(1);
                skip          = 1'b1;
            end
            for (int k = 0; k < int'(N); k++) begin
                hw = data_ext[16*k +: 16];
                if (skip) begin
                    // Upper half of an instruction already emitted.
                    skip = 1'b0;
                end else if (k >= int'(start_slot)) begin
                    if (hw[1:0] != 2'b11) begin
                        slot_valid[cnt[IW-1:0]] = 1'b1;
                        slot_instr[cnt[IW-1:0]] = {16'h0000, hw};
                        slot_addr[cnt[IW-1:0]]  = base + 64'(2 * k);
                        cnt = cnt + (IW+1)'(1);
                    end else if (k < int'(N) - 1) begin
                        slot_valid[cnt[IW-1:0]] = 1'b1;
                        slot_instr[cnt[IW-1:0]] = {data_ext[16*(k+1) +: 16], hw};
                        slot_addr[cnt[IW-1:0]]  = base + 64'(2 * k);
                        cnt  = cnt + (IW+1)'(1);
                        skip = 1'b1;
                    end else begin
                        unaligned_d  = 1'b1;
                        saved_hw_d   = hw;
                        saved_addr_d = base + 64'(2 * k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unaligned_q  <= 1'b0;
            saved_hw_q   <= '0;
            saved_addr_q <= '0;
        end else begin
            unaligned_q  <= unaligned_d;
            saved_hw_q   <= saved_hw_d;
            saved_addr_q <= saved_addr_d;
        end
    end

    assign bus.valid_o          = slot_valid;
    assign bus.instr_o          = slot_instr;
    assign bus.addr_o           = slot_addr;
    assign bus.unaligned_o      = unaligned_q;
    assign bus.unaligned_addr_o = saved_addr_q;

`ifndef SYNTHESIS
    // Valid slots are packed: valid_o has the form 0..01..1.
    a_valid_contiguous: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((slot_valid & (slot_valid + (N)'(1))) == '0));
    a_saved_addr_even: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (saved_addr_q[0] == 1'b0));
`endif
endmodule

// File: tb/tb_fetch_realign.sv
// -----------------------------------------------------------------------------
// tb_fetch_realign
//   Directed bench for fetch_realign at FETCH_WIDTH 32 and 64. Drivers push
//   expected (instr, PC) pairs into per-instance queues; a negedge monitor pops
//   one entry for every valid slot it sees. Drivers also check valid_o and the
//   held-half state after each clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_realign;
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] addr;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp32_q[$];
    exp_t exp64_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_realign_if #(.FETCH_WIDTH(32)) bus32 ();
    fetch_realign_if #(.FETCH_WIDTH(64)) bus64 ();

    fetch_realign #(.FETCH_WIDTH(32)) u_dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(bus32));
    fetch_realign #(.FETCH_WIDTH(64)) u_dut64 (.clk_i(clk), .rst_ni(rst_n), .bus(bus64));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp32(input logic [31:0] instr, input logic [63:0] addr);
        exp32_q.push_back('{instr: instr, addr: addr});
    endtask

    task automatic exp64(input logic [31:0] instr, input logic [63:0] addr);
        exp64_q.push_back('{instr: instr, addr: addr});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (bus32.valid_o[i] === 1'b1) begin
                if (exp32_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mon32 slot%0d: unexpected instr 0x%0h expected none", i, bus32.instr_o[i]);
                end else begin
                    e = exp32_q.pop_front();
                    check($sformatf("mon32 instr slot%0d", i), 64'(bus32.instr_o[i]), 64'(e.instr));
                    check($sformatf("mon32 addr slot%0d", i), bus32.addr_o[i], e.addr);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (bus64.valid_o[i] === 1'b1) begin
                if (exp64_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mon64 slot%0d: unexpected instr 0x%0h expected none", i, bus64.instr_o[i]);
                end else begin
                    e = exp64_q.pop_front();
                    check($sformatf("mon64 instr slot%0d", i), 64'(bus64.instr_o[i]), 64'(e.instr));
                    check($sformatf("mon64 addr slot%0d", i), bus64.addr_o[i], e.addr);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Called just after a posedge; returns just after the next posedge.
    task automatic step32(input logic v, input logic f, input logic [63:0] a,
                          input logic [31:0] d, input logic [1:0] mask,
                          input logic ua, input logic [63:0] ua_addr);
        bus32.valid_i   = v;
        bus32.flush_i   = f;
        bus32.address_i = a;
        bus32.data_i    = d;
        @(negedge clk);
        check("valid_o32", 64'(bus32.valid_o), 64'(mask));
        @(posedge clk);
        #1;
        check("unaligned_o32", 64'(bus32.unaligned_o), 64'(ua));
        if (ua) check("unaligned_addr_o32", bus32.unaligned_addr_o, ua_addr);
        bus32.valid_i = 1'b0;
        bus32.flush_i = 1'b0;
    endtask

    task automatic step64(input logic v, input logic f, input logic [63:0] a,
                          input logic [63:0] d, input logic [3:0] mask,
                          input logic ua, input logic [63:0] ua_addr);
        bus64.valid_i   = v;
        bus64.flush_i   = f;
        bus64.address_i = a;
        bus64.data_i    = d;
        @(negedge clk);
        check("valid_o64", 64'(bus64.valid_o), 64'(mask));
        @(posedge clk);
        #1;
        check("unaligned_o64", 64'(bus64.unaligned_o), 64'(ua));
        if (ua) check("unaligned_addr_o64", bus64.unaligned_addr_o, ua_addr);
        bus64.valid_i = 1'b0;
        bus64.flush_i = 1'b0;
    endtask

    // Block ending in a straddling half: 0x4501 @0x2000, 0x0513 held @0x2002.
    task automatic setup_straddle32();
        exp32(32'h0000_4501, 64'h2000);
        step32(1'b1, 1'b0, 64'h2000, 32'h0513_4501, 2'b01, 1'b1, 64'h2002);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n           = 1'b0;
        bus32.valid_i   = 1'b0;
        bus32.flush_i   = 1'b0;
        bus32.address_i = '0;
        bus32.data_i    = '0;
        bus64.valid_i   = 1'b0;
        bus64.flush_i   = 1'b0;
        bus64.address_i = '0;
        bus64.data_i    = '0;
        #3;
        check("reset unaligned_o32", 64'(bus32.unaligned_o), 64'h0);
        check("reset unaligned_addr_o32", bus32.unaligned_addr_o, 64'h0);
        check("reset valid_o32", 64'(bus32.valid_o), 64'h0);
        check("reset unaligned_o64", 64'(bus64.unaligned_o), 64'h0);
        check("reset valid_o64", 64'(bus64.valid_o), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Plain 32-bit instruction.
        exp32(32'h00A5_0513, 64'h1000);
        step32(1'b1, 1'b0, 64'h1000, 32'h00A5_0513, 2'b01, 1'b0, 64'h0);
        // Two RVC.
        exp32(32'h0000_4501, 64'h1000);
        exp32(32'h0000_4501, 64'h1002);
        step32(1'b1, 1'b0, 64'h1000, 32'h4501_4501, 2'b11, 1'b0, 64'h0);
        // Straddle across blocks.
        setup_straddle32();
        exp32(32'h00A5_0513, 64'h2002);
        exp32(32'h0000_4501, 64'h2006);
        step32(1'b1, 1'b0, 64'h2004, 32'h4501_00A5, 2'b11, 1'b0, 64'h0);
        // Mid-block start ignores the lower halfword.
        exp32(32'h0000_4501, 64'h3002);
        step32(1'b1, 1'b0, 64'h3002, 32'h4501_FFFF, 2'b01, 1'b0, 64'h0);
        // Flush (with valid_i also high) kills the held half.
        setup_straddle32();
        step32(1'b1, 1'b1, 64'h2004, 32'h4501_00A5, 2'b00, 1'b0, 64'h0);
        exp32(32'h0000_00A5, 64'h2004);
        exp32(32'h0000_4501, 64'h2006);
        step32(1'b1, 1'b0, 64'h2004, 32'h4501_00A5, 2'b11, 1'b0, 64'h0);
        // Held half goes stale when the next fetch starts mid-block.
        setup_straddle32();
        exp32(32'h0000_4501, 64'h2006);
        step32(1'b1, 1'b0, 64'h2006, 32'h4501_FFFF, 2'b01, 1'b0, 64'h0);
        // Stitch, then a new straddle in the same block, then stitch again.
        setup_straddle32();
        exp32(32'h00A5_0513, 64'h2002);
        step32(1'b1, 1'b0, 64'h2004, 32'h0513_00A5, 2'b01, 1'b1, 64'h2006);
        exp32(32'h00A5_0513, 64'h2006);
        exp32(32'h0000_4501, 64'h200A);
        step32(1'b1, 1'b0, 64'h2008, 32'h4501_00A5, 2'b11, 1'b0, 64'h0);
        // Hold for 3 idle cycles, then asynchronous reset mid-hold.
        setup_straddle32();
        for (int i = 0; i < 3; i++)
            step32(1'b0, 1'b0, 64'h5554, 32'hDEAD_BEEF, 2'b00, 1'b1, 64'h2002);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset unaligned_o32", 64'(bus32.unaligned_o), 64'h0);
        check("async reset unaligned_addr_o32", bus32.unaligned_addr_o, 64'h0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // No stitch after reset.
        exp32(32'h0000_00A5, 64'h2004);
        exp32(32'h0000_4501, 64'h2006);
        step32(1'b1, 1'b0, 64'h2004, 32'h4501_00A5, 2'b11, 1'b0, 64'h0);

        // FETCH_WIDTH = 64.
        exp64(32'h00A5_0513, 64'h4000);
        exp64(32'h0000_4501, 64'h4004);
        step64(1'b1, 1'b0, 64'h4000, 64'h0513_4501_00A5_0513, 4'b0011, 1'b1, 64'h4006);
        // Stitch plus three RVC fills all four slots.
        exp64(32'h00A5_0513, 64'h4006);
        exp64(32'h0000_4501, 64'h400A);
        exp64(32'h0000_4501, 64'h400C);
        exp64(32'h0000_4501, 64'h400E);
        step64(1'b1, 1'b0, 64'h4008, 64'h4501_4501_4501_00A5, 4'b1111, 1'b0, 64'h0);
        // Start in the last slot on a 32-bit half: nothing emitted, half held.
        step64(1'b1, 1'b0, 64'h4016, 64'h0513_4501_4501_4501, 4'b0000, 1'b1, 64'h4016);
        step64(1'b0, 1'b1, 64'h0, 64'h0, 4'b0000, 1'b0, 64'h0);
        // Start at slot 2 with a full 32-bit instruction in slots 2..3.
        exp64(32'h4501_0513, 64'h4024);
        step64(1'b1, 1'b0, 64'h4024, 64'h4501_0513_FFFF_FFFF, 4'b0001, 1'b0, 64'h0);

        @(negedge clk);
        check("exp32_q drained", 64'(exp32_q.size()), 64'h0);
        check("exp64_q drained", 64'(exp64_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
